// File: rtl/la_cmd_pkg.sv
// Shared opcodes, logic-analyzer bit positions and FSM states for the LA command responder.
package la_cmd_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_RUN   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  localparam int unsigned REQ_BIT  = 31;
  localparam int unsigned ACK_BIT  = 31;
  localparam int unsigned BUSY_BIT = 30;
  localparam int unsigned ERR_BIT  = 29;
  localparam int unsigned OPC_MSB  = 30;
  localparam int unsigned OPC_LSB  = 28;
  localparam int unsigned ADDR_MSB = 27;
  localparam int unsigned ADDR_LSB = 24;

  typedef enum logic [1:0] {StIdle, StExec, StRun, StAck} la_state_e;

endpackage

// File: rtl/event_sync_edge.sv
// Two-flop synchronizer for an asynchronous event line with a one-cycle rising-edge pulse.
module event_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic event_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], event_i};
    end
  end

  // sync_q[2] is only the previous synchronized level, used for edge detection.
  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/la_cmd_responder.sv
// Toggle-handshaked LA command decoder: register bank, timed event-count window, status word.
module la_cmd_responder
  import la_cmd_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [31:0]         la1_data_in,
  input  logic [31:0]         la1_oenb,
  output logic [31:0]         la1_data_out,
  input  logic                event_i,
  output logic [NREGS*DW-1:0] regs_o,
  output logic                run_o
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  la_state_e                   state_q, state_d;
  logic [31:0]                 la_q;
  logic                        oenb_q;
  logic                        ack_q, ack_d;
  logic                        err_q, err_d;
  logic [15:0]                 rdata_q, rdata_d;
  logic [2:0]                  opc_q, opc_d;
  logic [3:0]                  addr_q, addr_d;
  logic [15:0]                 wdata_q, wdata_d;
  logic [15:0]                 win_q, win_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        sat_q, sat_d;
  logic [NREGS-1:0][DW-1:0]    regs_q, regs_d;

  logic        pulse;
  logic        eff_req, pending, addr_ok;
  logic [15:0] cnt_nx;
  logic        sat_nx;
  logic        unused_la;

  event_sync_edge u_event_sync_edge (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .event_i (event_i),
    .pulse_o (pulse)
  );

  // A request bit the firmware is not driving is treated as "no request".
  assign eff_req = oenb_q ? ack_q : la_q[REQ_BIT];
  assign pending = eff_req ^ ack_q;
  assign addr_ok = 32'(addr_q) < NREGS;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    regs_d  = regs_q;
    cnt_nx  = cnt_q;
    sat_nx  = sat_q;
    unique case (state_q)
      StIdle: begin
        if (pending) begin
          opc_d   = la_q[OPC_MSB:OPC_LSB];
          addr_d  = la_q[ADDR_MSB:ADDR_LSB];
          wdata_d = la_q[15:0];
          state_d = StExec;
        end
      end
      StExec: begin
        // Result and ack toggle are registered together so firmware sees them atomically.
        state_d = StAck;
        ack_d   = ~ack_q;
        err_d   = 1'b0;
        rdata_d = '0;
        case (opc_q)
          OP_NOP: ;
          OP_WRITE: begin
            if (addr_ok) regs_d[addr_q[AW-1:0]] = wdata_q[DW-1:0];
            else         err_d = 1'b1;
          end
          OP_READ: begin
            if (addr_ok) rdata_d = 16'(regs_q[addr_q[AW-1:0]]);
            else         err_d = 1'b1;
          end
          OP_RUN: begin
            if (wdata_q != '0) begin
              state_d = StRun;
              ack_d   = ack_q;
              win_d   = wdata_q;
              cnt_d   = '0;
              sat_d   = 1'b0;
            end
          end
          OP_CLEAR: regs_d = '0;
          default:  err_d = 1'b1;
        endcase
      end
      StRun: begin
        if (pulse) begin
          if (cnt_q == 16'hFFFF) sat_nx = 1'b1;
          else                   cnt_nx = cnt_q + 16'd1;
        end
        cnt_d = cnt_nx;
        sat_d = sat_nx;
        win_d = win_q - 16'd1;
        if (win_q == 16'd1) begin
          state_d = StAck;
          ack_d   = ~ack_q;
          rdata_d = cnt_nx;
          err_d   = sat_nx;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      la_q    <= '0;
      oenb_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      opc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      la_q    <= la1_data_in;
      oenb_q  <= la1_oenb[REQ_BIT];
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      regs_q  <= regs_d;
    end
  end

  assign unused_la = ^{la1_oenb[30:0], la_q[23:16]};

  always_comb begin
    la1_data_out           = '0;
    la1_data_out[ACK_BIT]  = ack_q;
    la1_data_out[BUSY_BIT] = (state_q != StIdle);
    la1_data_out[ERR_BIT]  = err_q;
    la1_data_out[15:0]     = rdata_q;
  end

  assign regs_o = regs_q;
  assign run_o  = (state_q == StRun);

endmodule

// File: tb/tb_la_cmd_responder.sv
// Scoreboard bench for la_cmd_responder: commands push expected acks, a monitor pops them.
module tb_la_cmd_responder;
  import la_cmd_pkg::*;

  localparam int unsigned NREGS = 8;
  localparam int unsigned DW    = 16;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_ni = 1'b0;
  logic [31:0]         la1_data_in;
  logic [31:0]         la1_oenb;
  logic [31:0]         la1_data_out;
  logic                event_i;
  logic [NREGS*DW-1:0] regs_o;
  logic                run_o;

  la_cmd_responder #(.NREGS(NREGS), .DW(DW)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .la1_data_in  (la1_data_in),
    .la1_oenb     (la1_oenb),
    .la1_data_out (la1_data_out),
    .event_i      (event_i),
    .regs_o       (regs_o),
    .run_o        (run_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        rd_care;
    int unsigned issue_cyc;
    int unsigned lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned run_cnt = 0;
  int unsigned busy_gap = 0;
  logic        req = 1'b0;
  logic        last_ack = 1'b0;
  logic [DW-1:0] mregs [NREGS];

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < NREGS; k++) r[k*DW +: DW] = mregs[k];
    return r;
  endfunction

  // Event level follows cyc bit 2: a rising edge is driven whenever cyc % 8 == 4.
  initial begin
    event_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      event_i = cyc[2];
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_ni) begin
        last_ack = 1'b0;
      end else begin
        if (run_o) begin
          run_cnt++;
          if (!la1_data_out[BUSY_BIT]) busy_gap++;
        end
        if (la1_data_out[ACK_BIT] !== last_ack) begin
          last_ack = la1_data_out[ACK_BIT];
          if (sb.size() == 0) begin
            chk("spurious_ack", 128'(sb.size()), 128'd1);
          end else begin
            e = sb.pop_front();
            chk({e.tag, "_ack"}, 128'(last_ack), 128'(e.ack));
            chk({e.tag, "_lat"}, 128'(cyc - e.issue_cyc), 128'(e.lat));
            chk({e.tag, "_err"}, 128'(la1_data_out[ERR_BIT]), 128'(e.err));
            chk({e.tag, "_zero"}, 128'(la1_data_out[28:16]), 128'd0);
            if (e.rd_care) chk({e.tag, "_rdata"}, 128'(la1_data_out[15:0]), 128'(e.rdata));
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] wd,
                       input string tag, input bit expect_ack);
    exp_t e;
    @(negedge wb_clk_i);
    req = ~req;
    la1_data_in = {req, op, addr, 8'h00, wd};
    e.ack = req;
    e.err = 1'b0;
    e.rdata = 16'h0;
    e.rd_care = 1'b1;
    e.lat = 3;
    e.issue_cyc = cyc;
    e.tag = tag;
    case (op)
      OP_NOP: e.rd_care = 1'b0;
      OP_WRITE: begin
        if (32'(addr) < NREGS) begin
          mregs[addr[2:0]] = wd[DW-1:0];
          e.rd_care = 1'b0;
        end else begin
          e.err = 1'b1;
        end
      end
      OP_READ: begin
        if (32'(addr) < NREGS) e.rdata = 16'(mregs[addr[2:0]]);
        else                   e.err = 1'b1;
      end
      OP_RUN: begin
        if (wd != 16'h0) begin
          e.lat = 3 + 32'(wd);
          // Edges driven at cyc in [issue+1, issue+wd] land inside the window.
          for (int unsigned t = cyc + 1; t <= cyc + 32'(wd); t++) begin
            if (t % 8 == 4) e.rdata = e.rdata + 16'd1;
          end
        end
      end
      OP_CLEAR: for (int k = 0; k < NREGS; k++) mregs[k] = '0;
      default: e.err = 1'b1;
    endcase
    if (expect_ack) sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk({tag, "_drain"}, 128'(sb.size()), 128'd0);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] wd,
                     input string tag);
    issue(op, addr, wd, tag, 1'b1);
    wait_done(tag);
  endtask

  initial begin
    la1_data_in = '0;
    la1_oenb = '0;
    for (int k = 0; k < NREGS; k++) mregs[k] = '0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    chk("rst_out", 128'(la1_data_out), 128'd0);
    chk("rst_regs", regs_o, 128'd0);
    chk("rst_run", 128'(run_o), 128'd0);

    cmd(OP_WRITE, 4'd2, 16'hBEEF, "wr2");
    chk("wr2_regs", 128'(regs_o[47:32]), 128'hBEEF);
    cmd(OP_READ, 4'd2, 16'h0, "rd2");
    cmd(OP_WRITE, 4'd7, 16'h1234, "wr7");
    cmd(OP_READ, 4'd7, 16'h0, "rd7");
    cmd(OP_NOP, 4'd0, 16'h0, "nop");

    cmd(OP_READ, 4'd9, 16'h0, "rd9");
    cmd(3'd6, 4'd1, 16'h5555, "op6");
    cmd(OP_WRITE, 4'd12, 16'hDEAD, "wr12");
    chk("bad_regs", regs_o, mflat());

    run_cnt = 0;
    busy_gap = 0;
    cmd(OP_RUN, 4'd0, 16'd100, "run100");
    chk("run100_len", 128'(run_cnt), 128'd100);
    chk("run100_busy", 128'(busy_gap), 128'd0);

    run_cnt = 0;
    cmd(OP_RUN, 4'd0, 16'd0, "run0");
    chk("run0_len", 128'(run_cnt), 128'd0);

    cmd(OP_CLEAR, 4'd0, 16'h0, "clr");
    chk("clr_regs", regs_o, mflat());

    // Request bit masked by oenb: a toggle must not be acknowledged.
    la1_oenb[31] = 1'b1;
    @(negedge wb_clk_i);
    la1_data_in[31] = ~req;
    repeat (8) @(negedge wb_clk_i);
    chk("oenb_noack", 128'(la1_data_out[ACK_BIT]), 128'(req));
    la1_data_in[31] = req;
    repeat (2) @(negedge wb_clk_i);
    la1_oenb[31] = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    chk("oenb_noack2", 128'(la1_data_out[ACK_BIT]), 128'(req));

    cmd(OP_WRITE, 4'd3, 16'h55AA, "wr3");
    issue(OP_RUN, 4'd0, 16'd50, "run50", 1'b0);
    repeat (22) @(negedge wb_clk_i);
    chk("run50_active", 128'(run_o), 128'd1);
    @(posedge wb_clk_i);
    #2 wb_rst_ni = 1'b0;
    #1;
    chk("abort_out", 128'(la1_data_out), 128'd0);
    chk("abort_run", 128'(run_o), 128'd0);
    chk("abort_regs", regs_o, 128'd0);
    for (int k = 0; k < NREGS; k++) mregs[k] = '0;
    req = 1'b0;
    la1_data_in = '0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    cmd(OP_WRITE, 4'd5, 16'hA5A5, "post_rst");
    chk("post_rst_regs", regs_o, mflat());
    cmd(OP_READ, 4'd5, 16'h0, "post_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
